// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings for the unified memory arbiter: read-owner tags and
// requester indices used by the grant vector.
package unified_mem_arbiter_pkg;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_DR   = 2'd2;

    localparam int NREQ   = 3;
    localparam int REQ_IF = 0;
    localparam int REQ_DR = 1;
    localparam int REQ_WR = 2;

endpackage

// File: rtl/unified_mem_arbiter_prio_grant.sv
// Combinational 3-way priority encoder: write > data read > fetch, except that
// an asserted force input hands the slot to a requesting fetch.
module unified_mem_arbiter_prio_grant
    import unified_mem_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic            force_if_i,
    output logic [NREQ-1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        if (force_if_i && req_i[REQ_IF]) begin
            gnt_o[REQ_IF] = 1'b1;
        end else if (req_i[REQ_WR]) begin
            gnt_o[REQ_WR] = 1'b1;
        end else if (req_i[REQ_DR]) begin
            gnt_o[REQ_DR] = 1'b1;
        end else if (req_i[REQ_IF]) begin
            gnt_o[REQ_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port SRAM between fetch, data read and data write, with a
// fetch anti-starvation counter and 1-cycle read response routing by owner.
//
//   owner    | meaning
//   OWN_NONE | no read issued last cycle; any mem_rresp is dropped
//   OWN_IF   | last cycle's read belongs to instruction fetch
//   OWN_DR   | last cycle's read belongs to the data read port
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int MAXWAIT = 4,
    parameter int AW      = 30
) (
    input  logic          clk,
    input  logic          resetb,

    input  logic          imem_ready,
    input  logic [31:0]   imem_addr,
    output logic          imem_valid,
    output logic          imem_rresp,
    output logic [31:0]   imem_rdata,

    input  logic          dmem_rready,
    input  logic [31:0]   dmem_raddr,
    output logic          dmem_rvalid,
    output logic          dmem_rresp,
    output logic [31:0]   dmem_rdata,

    input  logic          dmem_wready,
    input  logic [31:0]   dmem_waddr,
    input  logic [31:0]   dmem_wdata,
    input  logic [3:0]    dmem_wstrb,
    output logic          dmem_wvalid,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic          mem_rresp,
    input  logic [31:0]   mem_rdata
);

    localparam logic [3:0] MAXWAIT_C = 4'(MAXWAIT);

    logic [1:0]      owner_q, owner_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic [NREQ-1:0] req, gnt_raw, gnt;
    logic [31:0]     sel_addr;
    logic            force_if;
    logic            unused_addr_bits;

    assign req[REQ_IF] = imem_ready;
    assign req[REQ_DR] = dmem_rready;
    assign req[REQ_WR] = dmem_wready;
    assign force_if    = (wait_cnt_q == MAXWAIT_C);

    unified_mem_arbiter_prio_grant u_prio_grant (
        .req_i      (req),
        .force_if_i (force_if),
        .gnt_o      (gnt_raw)
    );

    // Accepts are combinational, so they must be masked by reset directly.
    assign gnt         = gnt_raw & {NREQ{resetb}};
    assign imem_valid  = gnt[REQ_IF];
    assign dmem_rvalid = gnt[REQ_DR];
    assign dmem_wvalid = gnt[REQ_WR];

    always_comb begin
        sel_addr = 32'd0;
        if (gnt[REQ_WR]) begin
            sel_addr = dmem_waddr;
        end else if (gnt[REQ_DR]) begin
            sel_addr = dmem_raddr;
        end else if (gnt[REQ_IF]) begin
            sel_addr = imem_addr;
        end
    end

    assign mem_en    = |gnt;
    assign mem_we    = gnt[REQ_WR];
    assign mem_addr  = sel_addr[AW+1:2];
    assign mem_wdata = dmem_wdata;
    assign mem_wstrb = gnt[REQ_WR] ? dmem_wstrb : 4'h0;

    assign unused_addr_bits = ^sel_addr[1:0];

    always_comb begin
        owner_d = OWN_NONE;
        if (gnt[REQ_IF]) begin
            owner_d = OWN_IF;
        end else if (gnt[REQ_DR]) begin
            owner_d = OWN_DR;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!imem_ready || imem_valid) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q < MAXWAIT_C) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            owner_q    <= OWN_NONE;
            wait_cnt_q <= 4'd0;
        end else begin
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign imem_rresp = mem_rresp && (owner_q == OWN_IF);
    assign dmem_rresp = mem_rresp && (owner_q == OWN_DR);
    assign imem_rdata = mem_rdata;
    assign dmem_rdata = mem_rdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed per-cycle vectors push the
// expected accept and read response; a negedge monitor pops and compares.
module tb_unified_mem_arbiter;

    logic        clk;
    logic        resetb;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic        imem_rresp;
    logic [31:0] imem_rdata;
    logic        dmem_rready;
    logic [31:0] dmem_raddr;
    logic        dmem_rvalid;
    logic        dmem_rresp;
    logic [31:0] dmem_rdata;
    logic        dmem_wready;
    logic [31:0] dmem_waddr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_wvalid;
    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rresp;
    logic [31:0] mem_rdata;

    unified_mem_arbiter #(.MAXWAIT(4), .AW(30)) dut (
        .clk         (clk),
        .resetb      (resetb),
        .imem_ready  (imem_ready),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rresp  (imem_rresp),
        .imem_rdata  (imem_rdata),
        .dmem_rready (dmem_rready),
        .dmem_raddr  (dmem_raddr),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rresp  (dmem_rresp),
        .dmem_rdata  (dmem_rdata),
        .dmem_wready (dmem_wready),
        .dmem_waddr  (dmem_waddr),
        .dmem_wdata  (dmem_wdata),
        .dmem_wstrb  (dmem_wstrb),
        .dmem_wvalid (dmem_wvalid),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_rresp   (mem_rresp),
        .mem_rdata   (mem_rdata)
    );

    // who codes: 0 none, 1 fetch, 2 data read, 3 write
    typedef struct {
        int          cyc;
        int          who;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } acc_t;

    typedef struct {
        int          cyc;
        int          who;
        logic [31:0] data;
    } rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic inject = 1'b0;
    logic drop_rsp = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: read data one cycle after a read, content = 0xD0000000 | word addr.
    initial begin
        mem_rresp = 1'b0;
        mem_rdata = 32'd0;
    end
    always @(posedge clk) begin
        mem_rresp <= (mem_en && !mem_we) || inject;
        mem_rdata <= 32'hD000_0000 | {2'b00, mem_addr};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic ir, input logic [31:0] ia,
                        input logic rr, input logic [31:0] ra,
                        input logic wr, input logic [31:0] wa,
                        input logic [31:0] wd, input logic [3:0] ws, input int exp);
        acc_t e;
        rsp_t r;
        @(posedge clk);
        #1;
        inject      = 1'b0;
        imem_ready  = ir;
        imem_addr   = ia;
        dmem_rready = rr;
        dmem_raddr  = ra;
        dmem_wready = wr;
        dmem_waddr  = wa;
        dmem_wdata  = wd;
        dmem_wstrb  = ws;
        e.cyc   = cyc;
        e.who   = exp;
        e.addr  = (exp == 1) ? ia : (exp == 2) ? ra : (exp == 3) ? wa : 32'd0;
        e.wdata = wd;
        e.wstrb = ws;
        acc_q.push_back(e);
        if ((exp == 1 || exp == 2) && !drop_rsp) begin
            r.cyc  = cyc + 1;
            r.who  = exp;
            r.data = 32'hD000_0000 | {2'b00, e.addr[31:2]};
            rsp_q.push_back(r);
        end
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'h0, 0);
    endtask

    int   n_acc;
    int   who_dut;
    acc_t ea;
    rsp_t er;

    always @(negedge clk) begin
        if (resetb) begin
            n_acc   = int'(imem_valid) + int'(dmem_rvalid) + int'(dmem_wvalid);
            who_dut = dmem_wvalid ? 3 : dmem_rvalid ? 2 : imem_valid ? 1 : 0;
            chk("one_accept", 32'(n_acc > 1), 32'd0);
            if (acc_q.size() > 0 && acc_q[0].cyc == cyc) begin
                ea = acc_q.pop_front();
                chk("grant", 32'(who_dut), 32'(ea.who));
                chk("mem_en", 32'(mem_en), 32'(ea.who != 0));
                chk("mem_wstrb", 32'(mem_wstrb), (ea.who == 3) ? 32'(ea.wstrb) : 32'd0);
                if (ea.who != 0) begin
                    chk("mem_addr", 32'(mem_addr), 32'(ea.addr[31:2]));
                    chk("mem_we", 32'(mem_we), 32'(ea.who == 3));
                end
                if (ea.who == 3) chk("mem_wdata", mem_wdata, ea.wdata);
            end else begin
                chk("unexpected_accept", 32'(n_acc), 32'd0);
            end

            if (imem_rresp || dmem_rresp) begin
                chk("rresp_exclusive", 32'(imem_rresp && dmem_rresp), 32'd0);
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rresp", 32'({imem_rresp, dmem_rresp}), 32'd0);
                end else begin
                    er = rsp_q.pop_front();
                    chk("rresp_cycle", 32'(cyc), 32'(er.cyc));
                    chk("rresp_owner", dmem_rresp ? 32'd2 : 32'd1, 32'(er.who));
                    chk("rdata", (er.who == 1) ? imem_rdata : dmem_rdata, er.data);
                end
            end else if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
                er = rsp_q.pop_front();
                chk("missing_rresp", 32'({dmem_rresp, imem_rresp}), 32'(er.who));
            end
        end
    end

    initial begin
        resetb      = 1'b0;
        imem_ready  = 1'b1;
        imem_addr   = 32'h100;
        dmem_rready = 1'b1;
        dmem_raddr  = 32'h200;
        dmem_wready = 1'b1;
        dmem_waddr  = 32'h300;
        dmem_wdata  = 32'hFFFF_FFFF;
        dmem_wstrb  = 4'hF;

        // Requests held high during reset must not be accepted.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_valid", 32'(imem_valid), 32'd0);
        chk("rst_dmem_rvalid", 32'(dmem_rvalid), 32'd0);
        chk("rst_dmem_wvalid", 32'(dmem_wvalid), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_rresp", 32'({imem_rresp, dmem_rresp}), 32'd0);

        @(posedge clk);
        #1;
        imem_ready  = 1'b0;
        dmem_rready = 1'b0;
        dmem_wready = 1'b0;
        resetb      = 1'b1;

        // Lone fetch at 0x100 -> word 0x40
        step(1, 32'h100, 0, 32'd0, 0, 32'd0, 32'd0, 4'h0, 1);
        idle();

        // Write beats read; read accepted the next cycle
        step(0, 32'd0, 1, 32'h3000, 1, 32'h20000, 32'hCAFE_BABE, 4'b0011, 3);
        step(0, 32'd0, 1, 32'h3000, 0, 32'd0, 32'd0, 4'h0, 2);
        idle();

        // Back-to-back reads: fetch then data read
        step(1, 32'h200, 0, 32'd0, 0, 32'd0, 32'd0, 4'h0, 1);
        step(0, 32'd0, 1, 32'h400, 0, 32'd0, 32'd0, 4'h0, 2);
        idle();
        idle();

        // Starvation against data read: 4 losses, forced grant, counter restarts
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < 4; i++)
                step(1, 32'h80, 1, 32'h500, 0, 32'd0, 32'd0, 4'h0, 2);
            step(1, 32'h80, 1, 32'h500, 0, 32'd0, 32'd0, 4'h0, 1);
        end
        idle();

        // Forced fetch beats a pending write
        for (int i = 0; i < 4; i++)
            step(1, 32'h84, 0, 32'd0, 1, 32'h600, 32'h1122_3344, 4'hF, 3);
        step(1, 32'h84, 0, 32'd0, 1, 32'h600, 32'h1122_3344, 4'hF, 1);
        step(0, 32'd0, 0, 32'd0, 1, 32'h600, 32'h1122_3344, 4'hF, 3);
        idle();

        // All three at once: write, then read, then fetch
        step(1, 32'h88, 1, 32'h700, 1, 32'h604, 32'h5566_7788, 4'b1000, 3);
        step(1, 32'h88, 1, 32'h700, 0, 32'd0, 32'd0, 4'h0, 2);
        step(1, 32'h88, 0, 32'd0, 0, 32'd0, 32'd0, 4'h0, 1);
        idle();

        // Idle with a stray memory response while no read is owned
        idle();
        inject = 1'b1;
        idle();
        idle();
        idle();

        // Reset between fetch grant and its response
        drop_rsp = 1'b1;
        step(1, 32'h300, 0, 32'd0, 0, 32'd0, 32'd0, 4'h0, 1);
        @(posedge clk);
        #1;
        resetb = 1'b0;
        #1;
        chk("midrst_imem_rresp", 32'(imem_rresp), 32'd0);
        chk("midrst_dmem_rresp", 32'(dmem_rresp), 32'd0);
        chk("midrst_imem_valid", 32'(imem_valid), 32'd0);
        chk("midrst_mem_en", 32'(mem_en), 32'd0);
        drop_rsp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        imem_ready = 1'b0;
        resetb     = 1'b1;

        // Reissue after reset
        step(1, 32'h104, 0, 32'd0, 0, 32'd0, 32'd0, 4'h0, 1);
        idle();
        idle();

        @(posedge clk);
        #1;
        chk("acc_queue_empty", 32'(acc_q.size()), 32'd0);
        chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port SRAM between the core's three memory requesters: instruction fetch, data read and data write. It is used in the single-memory build variant, which replaces the separate instruction and data memories.
- Each requester keeps the core's existing request/accept handshake: `*_ready` is the request from the core, `*_valid` is the accept from memory.
- Arbitration uses fixed priority plus an anti-starvation guarantee for fetch.
- Read data is returned to whichever requester owned the issued read.

Parameters:
- `MAXWAIT`, default 4: number of consecutive lost cycles after which fetch is force-granted. Legal range 1..15.
- `AW`, default 30: word-address width of the memory (byte address bits [31:2]).

Ports:
- `clk`  in  1  clock
- `resetb`  in  1  asynchronous active-low reset
- `imem_ready`  in  1  fetch read request
- `imem_addr`  in  32  fetch byte address
- `imem_valid`  out  1  fetch accepted this cycle
- `imem_rresp`  out  1  fetch data valid
- `imem_rdata`  out  32  fetch data
- `dmem_rready`  in  1  data read request
- `dmem_raddr`  in  32  data read byte address
- `dmem_rvalid`  out  1  data read accepted
- `dmem_rresp`  out  1  data read data valid
- `dmem_rdata`  out  32  data read data
- `dmem_wready`  in  1  data write request
- `dmem_waddr`  in  32  write byte address
- `dmem_wdata`  in  32  write data
- `dmem_wstrb`  in  4  byte enables
- `dmem_wvalid`  out  1  write accepted
- `mem_en`  out  1  memory access this cycle
- `mem_we`  out  1  write (1) or read (0)
- `mem_addr`  out  AW  word address
- `mem_wdata`  out  32  write data
- `mem_wstrb`  out  4  byte enables
- `mem_rresp`  in  1  memory read data valid (asserted one cycle after a read)
- `mem_rdata`  in  32  memory read data

Behaviour:
- Clocking and reset: one clock `clk`; reset `resetb` is asynchronous and active-low.
- Values while `resetb`=0:
  - all accepts (`imem_valid`, `dmem_rvalid`, `dmem_wvalid`) = 0;
  - `mem_en` = 0;
  - `imem_rresp` = `dmem_rresp` = 0;
  - `owner` = NONE; `wait_cnt` = 0.
- Grant logic is combinational and valid in the same cycle as the request. At most one accept is high per cycle.
- Priority when `wait_cnt` < `MAXWAIT`: write > data read > fetch.
- When `wait_cnt` == `MAXWAIT` and `imem_ready`=1: fetch wins over both data requests. A losing data requester simply holds its request.
- A requester holds its request, address and data stable until accepted. The arbiter never buffers a request.
- Memory drive:
  - `mem_en` = OR of the accepts.
  - `mem_we` = `dmem_wvalid`.
  - `mem_addr` = winner's address [AW+1:2].
  - `mem_wdata` and `mem_wstrb` pass through from the write port. `mem_wstrb` = 0 unless a write is granted.
- Owner register (NONE/IF/DR):
  - On a read grant, `owner` <= IF or DR at the next edge.
  - With no read grant, `owner` <= NONE.
- Response routing:
  - `imem_rresp` = `mem_rresp` && `owner`==IF.
  - `dmem_rresp` = `mem_rresp` && `owner`==DR.
  - `imem_rdata` and `dmem_rdata` both = `mem_rdata` (broadcast).
  - A `mem_rresp` arriving with `owner`==NONE is dropped.
- Back-to-back reads are allowed every cycle (pipelined, 1-cycle latency). The response of a read always follows its own grant, because `owner` is re-registered each cycle.
- Starvation counter `wait_cnt` (4 bits):
  - increments when `imem_ready` && !`imem_valid`;
  - saturates at `MAXWAIT`;
  - clears to 0 when `imem_valid`=1 or `imem_ready`=0.
- Simultaneous events:
  - write+read+fetch in one cycle: only the write is accepted; the others wait.
  - fetch force-grant has precedence over a pending write.
- Reset mid-operation: an in-flight read response is discarded because `owner` clears asynchronously. Requesters reissue after reset.
- No address-range checking; that is left to the memory model and the bench.

Decomposition:
- Shared package or header holds:
  - owner encodings: `OWN_NONE`=2'd0, `OWN_IF`=2'd1, `OWN_DR`=2'd2;
  - requester index constants.
- One natural sub-module: `prio_grant`, a combinational 3-way priority encoder with a force input. All sequential state (`owner`, `wait_cnt`) stays in the top block.

Test Plan:
1. Lone fetch:
   - Stimulus: `imem_ready`=1, `imem_addr`=0x100.
   - Response: `imem_valid`=1 in the same cycle, `mem_addr`=0x40, `mem_we`=0. Next cycle: `imem_rresp`=1 with `mem_rdata` passed through.
2. Write/read conflict:
   - Stimulus: `dmem_wready`=1 and `dmem_rready`=1 in the same cycle, `waddr`=0x20000, `wstrb`=4'b0011.
   - Response: `dmem_wvalid`=1 and `dmem_rvalid`=0 that cycle; `dmem_rvalid`=1 on the following cycle.
3. Starvation:
   - Stimulus: `dmem_rready` held at 1 continuously, `imem_ready`=1, `MAXWAIT`=4.
   - Response: fetch loses 4 cycles, is accepted on the 5th, then `wait_cnt` returns to 0.
4. Back-to-back reads:
   - Stimulus: fetch granted at cycle N, data read granted at cycle N+1.
   - Response: `imem_rresp` only at N+1, `dmem_rresp` only at N+2, never both in one cycle.
5. Reset mid-read:
   - Stimulus: assert `resetb`=0 asynchronously between the grant and `mem_rresp`.
   - Response: no `*_rresp` pulse; all outputs read 0 immediately.
6. Idle:
   - Stimulus: no requests.
   - Response: `mem_en`=0, `mem_wstrb`=0, `owner`=NONE.
